// File: rtl/sr_flag_arbiter_if.sv
// Requester-side bus for sr_flag_arbiter: per-requester SR commands, one-hot grant,
// flag bank state and error reporting.
interface sr_flag_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_s;
    logic [NREQ-1:0]      req_r;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ-1:0]      req_ready;
    logic [NFLAG-1:0]     flags;
    logic                 err;
    logic [7:0]           err_cnt;

    modport master (
        output req_valid, req_s, req_r, req_idx, req_lock,
        input  req_ready, flags, err, err_cnt
    );

    modport slave (
        input  req_valid, req_s, req_r, req_idx, req_lock,
        output req_ready, flags, err, err_cnt
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter applying one SR command per falling clk edge to a flag bank,
// with bank locking. Define SR_ARB_ERRCNT_EN to add the saturating error counter.
module sr_flag_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDXW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    sr_flag_arbiter_if.slave  bus
);
    localparam int PTRW = $clog2(NREQ);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PTRW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0]   owner_q, owner_d;
    logic [NFLAG-1:0]  flags_q, flags_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   grant_oh;
    logic [PTRW-1:0]   grant_id;
    logic [PTRW-1:0]   cand;
    logic              xfer;

    logic              cmd_s, cmd_r, cmd_lock;
    logic [IDXW-1:0]   cmd_idx;
    logic              idx_ok;

    function automatic logic [PTRW-1:0] ptr_add(input logic [PTRW-1:0] base, input int off);
        return PTRW'((int'(base) + off) % NREQ);
    endfunction

    // Grant selection. The scan runs from the farthest candidate towards rr_ptr so the
    // nearest valid requester is the last one written and therefore wins.
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        grant_oh = '0;
        grant_id = '0;
        cand     = '0;
        if (state_q == ST_LOCKED) begin
            if (bus.req_valid[owner_q]) begin
                grant_oh[owner_q] = 1'b1;
                grant_id          = owner_q;
            end
        end else begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                cand = ptr_add(rr_ptr_q, k);
                if (bus.req_valid[cand]) begin
                    grant_oh       = '0;
                    grant_oh[cand] = 1'b1;
                    grant_id       = cand;
                end
            end
        end
    end

    // Nothing is accepted while reset is held, even though the grant logic is combinational.
    assign bus.req_ready = grant_oh & {NREQ{rst}};
    assign xfer          = |bus.req_ready;

    always_comb begin
        cmd_s    = 1'b0;
        cmd_r    = 1'b0;
        cmd_lock = 1'b0;
        cmd_idx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) begin
                cmd_s    = bus.req_s[i];
                cmd_r    = bus.req_r[i];
                cmd_lock = bus.req_lock[i];
                cmd_idx  = bus.req_idx[i*IDXW +: IDXW];
            end
        end
    end

    assign idx_ok = (int'(cmd_idx) < NFLAG);

    // Flag bank update: S=R=1 and out-of-range indices leave the bank untouched and pulse err.
    always_comb begin
        flags_d = flags_q;
        err_d   = 1'b0;
        if (xfer) begin
            if (!idx_ok || (cmd_s && cmd_r)) begin
                err_d = 1'b1;
            end else begin
                for (int f = 0; f < NFLAG; f++) begin
                    if (int'(cmd_idx) == f) begin
                        if (cmd_s) begin
                            flags_d[f] = 1'b1;
                        end else if (cmd_r) begin
                            flags_d[f] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Lock FSM and round-robin pointer; both move only on an accepted command.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (xfer) begin
            case (state_q)
                ST_ARB: begin
                    if (cmd_lock) begin
                        owner_d = grant_id;
                        state_d = ST_LOCKED;
                    end else begin
                        rr_ptr_d = ptr_add(grant_id, 1);
                    end
                end
                ST_LOCKED: begin
                    if (!cmd_lock) begin
                        rr_ptr_d = ptr_add(owner_q, 1);
                        state_d  = ST_ARB;
                    end
                end
                default: state_d = ST_ARB;
            endcase
        end
    end

    // NOTE: the flag bank is a handful of flops, not a RAM, so it is reset along with the rest.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

    assign bus.flags = flags_q;
    assign bus.err   = err_q;

`ifdef SR_ARB_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: the driver queues the expected result of each
// transfer, the monitor pops and compares whenever a valid&&ready transfer is presented.
module tb_sr_flag_arbiter;
    localparam int NREQ  = 4;
    localparam int NFLAG = 8;
    localparam int IDXW  = 4;

    typedef struct {
        logic [3:0] ready;
        logic [7:0] flags;
        logic       err;
        logic [7:0] cnt;
        string      name;
    } exp_t;

    logic clk;
    logic rst;
    logic mon_en;
    int   n_checks;
    int   n_pass;
    int   n_illegal;
    logic [7:0] last_flags;
    logic [7:0] last_cnt;
    exp_t sb_q[$];

    sr_flag_arbiter_if #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) bus ();

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] cnt_model();
`ifdef SR_ARB_ERRCNT_EN
        return (n_illegal > 255) ? 8'hFF : 8'(n_illegal);
`else
        return 8'h00;
`endif
    endfunction

    task automatic push(input logic [3:0] rdy, input logic [7:0] fl, input logic er, input string nm);
        exp_t e;
        if (er) n_illegal++;
        e.ready = rdy;
        e.flags = fl;
        e.err   = er;
        e.cnt   = cnt_model();
        e.name  = nm;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic v, input logic s, input logic r,
                           input int idx, input logic lk);
        bus.req_valid[i]          = v;
        bus.req_s[i]              = s;
        bus.req_r[i]              = r;
        bus.req_idx[i*IDXW +: IDXW] = IDXW'(idx);
        bus.req_lock[i]           = lk;
    endtask

    task automatic drop(input int i);
        set_req(i, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Monitor: a transfer is visible mid-cycle (posedge); its result is checked just after
    // the falling edge. Cycles without a transfer must show no err and an unchanged bank.
    initial begin : monitor
        exp_t e;
        bit   pending;
        bit   have;
        forever begin
            @(posedge clk);
            if (!mon_en) continue;
            pending = |(bus.req_valid & bus.req_ready);
            have    = 1'b0;
            if (pending) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_xfer", 32'(bus.req_ready), 32'h0);
                end else begin
                    e    = sb_q.pop_front();
                    have = 1'b1;
                    check({e.name, "_ready"}, 32'(bus.req_ready), 32'(e.ready));
                end
            end
            @(negedge clk);
            #1;
            if (!mon_en) continue;
            if (have) begin
                check({e.name, "_flags"}, 32'(bus.flags), 32'(e.flags));
                check({e.name, "_err"}, 32'(bus.err), 32'(e.err));
                check({e.name, "_errcnt"}, 32'(bus.err_cnt), 32'(e.cnt));
                last_flags = e.flags;
                last_cnt   = e.cnt;
            end else begin
                check("idle_err", 32'(bus.err), 32'h0);
                check("idle_flags", 32'(bus.flags), 32'(last_flags));
                check("idle_errcnt", 32'(bus.err_cnt), 32'(last_cnt));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        n_checks      = 0;
        n_pass        = 0;
        n_illegal     = 0;
        last_flags    = 8'h00;
        last_cnt      = 8'h00;
        mon_en        = 1'b0;
        rst           = 1'b0;
        bus.req_valid = '0;
        bus.req_s     = '0;
        bus.req_r     = '0;
        bus.req_idx   = '0;
        bus.req_lock  = '0;

        #3;
        check("rst_flags", 32'(bus.flags), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_errcnt", 32'(bus.err_cnt), 32'h0);
        check("rst_ready", 32'(bus.req_ready), 32'h0);
        step();
        rst    = 1'b1;
        mon_en = 1'b1;

        // Single set from requester 1
        set_req(1, 1, 1, 0, 2, 0); push(4'b0010, 8'h04, 0, "t1_set");  step(); drop(1);
        // No-op from requester 3 brings rr_ptr back to 0
        set_req(3, 1, 0, 0, 6, 0); push(4'b1000, 8'h04, 0, "noop3");   step(); drop(3);

        // All four valid: round-robin order 0,1,2,3
        for (int i = 0; i < 4; i++) set_req(i, 1, 1, 0, i, 0);
        push(4'b0001, 8'h05, 0, "rr0");
        push(4'b0010, 8'h07, 0, "rr1");
        push(4'b0100, 8'h07, 0, "rr2");
        push(4'b1000, 8'h0F, 0, "rr3");
        for (int i = 0; i < 4; i++) begin
            step();
            drop(i);
        end

        // rr_ptr is back at 0: requester 0 beats requester 3
        set_req(0, 1, 0, 1, 0, 0); set_req(3, 1, 0, 1, 3, 0);
        push(4'b0001, 8'h0E, 0, "ptr_wrap");
        push(4'b1000, 8'h06, 0, "ptr_next");
        step(); drop(0);
        step(); drop(3);
        set_req(1, 1, 0, 0, 0, 0); push(4'b0010, 8'h06, 0, "noop1"); step(); drop(1);

        // Requester 2 locks while requester 0 waits
        set_req(0, 1, 1, 0, 4, 0);
        set_req(2, 1, 1, 0, 5, 1); push(4'b0100, 8'h26, 0, "lock_set"); step();
        drop(2);                                                        step();
        set_req(2, 1, 0, 1, 5, 0); push(4'b0100, 8'h06, 0, "lock_clr"); step(); drop(2);
        push(4'b0001, 8'h16, 0, "after_unlock");                        step(); drop(0);

        // Multi-flag locked sequence from requester 1
        set_req(1, 1, 1, 0, 7, 1); push(4'b0010, 8'h96, 0, "seq_a"); step();
        set_req(1, 1, 0, 1, 1, 1); push(4'b0010, 8'h94, 0, "seq_b"); step();
        set_req(1, 1, 0, 1, 2, 1); push(4'b0010, 8'h90, 0, "seq_c"); step();
        set_req(1, 1, 0, 1, 4, 0); push(4'b0010, 8'h80, 0, "seq_d"); step(); drop(1);

        // Illegal S=R=1, then a quiet cycle, then a long illegal burst to saturate err_cnt
        set_req(3, 1, 1, 1, 7, 0); push(4'b1000, 8'h80, 1, "illegal"); step(); drop(3);
        step();
        set_req(3, 1, 1, 1, 7, 0);
        for (int n = 0; n < 299; n++) begin
            push(4'b1000, 8'h80, 1, "illegal_sat");
            step();
        end
        drop(3);
        step();

        // Out-of-range indices
        set_req(0, 1, 1, 0, 9, 0); push(4'b0001, 8'h80, 1, "oor_9"); step(); drop(0);
        set_req(2, 1, 0, 1, 8, 0); push(4'b0100, 8'h80, 1, "oor_8"); step(); drop(2);

        // Build 8'h3C under a lock held by requester 1
        set_req(1, 1, 1, 0, 2, 1); push(4'b0010, 8'h84, 0, "lk_2"); step();
        set_req(1, 1, 1, 0, 3, 1); push(4'b0010, 8'h8C, 0, "lk_3"); step();
        set_req(1, 1, 1, 0, 4, 1); push(4'b0010, 8'h9C, 0, "lk_4"); step();
        set_req(1, 1, 1, 0, 5, 1); push(4'b0010, 8'hBC, 0, "lk_5"); step();
        set_req(1, 1, 0, 1, 7, 1); push(4'b0010, 8'h3C, 0, "lk_7"); step();

        // Asynchronous reset between edges while locked
        #1;
        mon_en = 1'b0;
        rst    = 1'b0;
        #1;
        check("midrst_flags", 32'(bus.flags), 32'h0);
        check("midrst_ready", 32'(bus.req_ready), 32'h0);
        check("midrst_err", 32'(bus.err), 32'h0);
        check("midrst_errcnt", 32'(bus.err_cnt), 32'h0);
        drop(1);
        set_req(3, 1, 1, 0, 0, 0);
        step();
        check("inrst_ready", 32'(bus.req_ready), 32'h0);
        n_illegal  = 0;
        last_flags = 8'h00;
        last_cnt   = 8'h00;
        rst        = 1'b1;
        mon_en     = 1'b1;
        push(4'b1000, 8'h01, 0, "post_rst"); step(); drop(3);
        step();
        step();

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sr_flag_arbiter.md
Name: sr_flag_arbiter

Overview:
Round-robin arbiter and sequencer for a bank of NFLAG set/reset flag cells shared by NREQ requesters. Each requester issues SR-style commands (set, clear, hold, illegal) against one flag index. The arbiter grants one command per clock, applies it to the flag bank and flags illegal S=R=1 commands. A requester may lock the bank for back-to-back multi-flag sequences. It sits between the control requesters and the flag outputs that drive downstream logic.

Parameters:
NREQ, 4, number of requesters (2..8)
NFLAG, 8, number of SR flag cells
IDXW, 3, flag index width; must satisfy 2**IDXW >= NFLAG

Ports:
clk  in  1  clock; all state updates on the falling edge of clk
rst  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester command valid
req_s  in  NREQ  per-requester set bit
req_r  in  NREQ  per-requester reset bit
req_idx  in  NREQ*IDXW  per-requester flag index; requester i uses bits [i*IDXW +: IDXW]
req_lock  in  NREQ  hold grant after this transfer
req_ready  out  NREQ  one-hot grant; command accepted when valid && ready
flags  out  NFLAG  flag bank state
err  out  1  one-cycle pulse on an illegal or out-of-range command
err_cnt  out  8  illegal-command counter (see Optional Feature)

Behaviour:
- Reset (rst=0, asynchronous): flags=0, rr_ptr=0, state=ARB, owner=0, err=0, err_cnt=0. Reset is not gated by clk.
- req_ready is combinational from state, rr_ptr, owner and req_valid. It is never asserted without the matching req_valid. At most one bit is set.
- ARB state:
  - Grant goes to the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - No valid requester -> req_ready=0 and no state change.
- LOCKED state:
  - Only req_ready[owner] may assert. Other requesters stall even if valid.
- Requesters hold valid, s, r, idx and lock stable until accepted. Dropping valid before ready is legal; the request is simply withdrawn.
- On a transfer from requester g at the falling edge (flag k = req_idx[g]):
  - s=0, r=0: flags[k] unchanged (no-op, still consumes the grant).
  - s=1, r=0: flags[k] <= 1.
  - s=0, r=1: flags[k] <= 0.
  - s=1, r=1: flags[k] unchanged, err <= 1 for one cycle.
  - k >= NFLAG: no flag changes, err <= 1.
  - New flag value is visible on flags after that edge; latency is 1 edge.
- err is 0 on any edge without an illegal transfer.
- Pointer and lock FSM, evaluated on each transfer:
  - ARB, lock=0: rr_ptr <= (g+1) mod NREQ, stay in ARB.
  - ARB, lock=1: owner <= g, go to LOCKED; rr_ptr unchanged.
  - LOCKED, lock=1: stay in LOCKED.
  - LOCKED, lock=0: rr_ptr <= (owner+1) mod NREQ, go to ARB.
- In LOCKED, if req_valid[owner] drops, stay in LOCKED. The owner must release the bank by issuing a command with lock=0; a no-op is allowed for this.
- Only one command per edge, so a flag never receives simultaneous writes.
- Reset asserted mid-lock or mid-sequence clears everything immediately. Pending requests are re-arbitrated from requester 0 after release.

Optional Feature:
Macro SR_ARB_ERRCNT_EN.
- Defined: err_cnt is an 8-bit saturating counter.
  - Increments on every edge where err is set.
  - Holds at 255.
  - Cleared only by rst.
- Not defined: err_cnt is tied to 0, no counter register exists, and err behaviour is unchanged.

Test Plan:
- Reset, then requester 1 set on idx 2 -> req_ready=4'b0010; after the edge flags=8'h04, err=0.
- All four requesters valid, lock=0, set idx 0..3 respectively, from rr_ptr=0 -> grants in order 0,1,2,3 on consecutive edges; flags=8'h0F; rr_ptr returns to 0.
- Requester 2 sets idx 5 with lock=1, then clears idx 5 with lock=0, while requester 0 is valid throughout -> req_ready stays 4'b0100 for both edges; flags bit 5 goes 1 then 0; requester 0 is granted on the third edge.
- Requester 3 issues s=1, r=1 on idx 7 with flags=8'h80 -> flags stays 8'h80; err=1 for exactly one cycle. With SR_ARB_ERRCNT_EN defined, err_cnt=1; after 300 such commands, err_cnt=255.
- Requester 0 uses idx 9 with NFLAG=8, IDXW=4 -> flags unchanged, err pulses, grant consumed.
- While LOCKED with flags=8'h3C, assert rst=0 between clk edges -> flags=0, req_ready=0 immediately. After release, a valid requester 3 alone is granted.
